// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the DataMemory port between the MEM stage (p0) and the SAD burst reader (p1)
module dmem_port_arbiter #(
    parameter int LEN_W     = 8,
    parameter int P0_STARVE = 4,
    parameter int P1_STARVE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [31:0]      p0_addr,
    input  logic [31:0]      p0_wdata,
    input  logic [4:0]       p0_aluCode,
    output logic             p0_gnt,
    output logic [31:0]      p0_rdata,
    output logic             stall,
    input  logic             p1_req,
    input  logic [31:0]      p1_addr,
    input  logic [LEN_W-1:0] p1_len,
    output logic             p1_busy,
    output logic             p1_valid,
    output logic [31:0]      p1_rdata,
    output logic             p1_done,
    output logic [31:0]      mem_Address,
    output logic [31:0]      mem_WriteData,
    output logic             mem_MemWrite,
    output logic             mem_MemRead,
    output logic [4:0]       mem_aluCode,
    input  logic [31:0]      mem_ReadData
);

    localparam int P0W_W = $clog2(P0_STARVE + 1);
    localparam int P1W_W = $clog2(P1_STARVE + 1);
    localparam logic [P0W_W-1:0] P0_LIM = P0W_W'(P0_STARVE);
    localparam logic [P1W_W-1:0] P1_LIM = P1W_W'(P1_STARVE);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             r_state;
    logic [31:0]        r_cur_addr;
    logic [LEN_W-1:0]   r_remaining;
    logic [P0W_W-1:0]   r_p0_wait;
    logic [P1W_W-1:0]   r_p1_wait;
    logic               r_p1_valid;
    logic [31:0]        r_p1_rdata;
    logic               r_done_pend;
    logic               r_p1_done;

    logic w_in_burst;
    logic w_tail;
    logic w_p1_accept;
    logic w_p0_preempt;
    logic w_p0_gnt;
    logic w_p1_read;
    logic w_last_read;

    // After the last read the burst stays busy for the trailing valid and done cycles
    assign w_in_burst   = (r_state == S_BURST);
    assign w_tail       = r_p1_valid | r_p1_done;
    assign w_p1_accept  = ~w_in_burst & ~w_tail & p1_req & (~p0_req | (r_p1_wait == P1_LIM));
    assign w_p0_preempt = w_in_burst & p0_req & (r_p0_wait == P0_LIM);
    assign w_p0_gnt     = w_in_burst ? w_p0_preempt : (p0_req & ~w_p1_accept);
    assign w_p1_read    = w_in_burst & ~w_p0_preempt;
    assign w_last_read  = w_p1_read & (r_remaining == LEN_W'(1));

    assign p0_gnt   = w_p0_gnt;
    assign p0_rdata = mem_ReadData;
    assign stall    = p0_req & ~w_p0_gnt;
    assign p1_busy  = w_in_burst | w_tail | w_p1_accept;
    assign p1_valid = r_p1_valid;
    assign p1_rdata = r_p1_rdata;
    assign p1_done  = r_p1_done;

    // Memory port mux: the granted requester drives the port, otherwise it is quiet
    always_comb begin
        mem_Address   = '0;
        mem_WriteData = '0;
        mem_MemWrite  = 1'b0;
        mem_MemRead   = 1'b0;
        mem_aluCode   = '0;
        if (w_p0_gnt) begin
            mem_Address   = p0_addr;
            mem_WriteData = p0_wdata;
            mem_MemWrite  = p0_we;
            mem_MemRead   = ~p0_we;
            mem_aluCode   = p0_aluCode;
        end else if (w_p1_read) begin
            mem_Address = r_cur_addr;
            mem_MemRead = 1'b1;
        end
    end

    // Burst FSM, fairness counters and registered burst outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_p0_wait   <= '0;
            r_p1_wait   <= '0;
            r_p1_valid  <= 1'b0;
            r_p1_rdata  <= '0;
            r_done_pend <= 1'b0;
            r_p1_done   <= 1'b0;
        end else begin
            r_p1_valid  <= w_p1_read;
            r_done_pend <= w_last_read;
            r_p1_done   <= r_done_pend | (w_p1_accept & (p1_len == '0));
            if (w_p1_read) begin
                r_p1_rdata <= mem_ReadData;
            end
            case (r_state)
                S_IDLE: begin
                    r_p0_wait <= '0;
                    if (w_p1_accept) begin
                        r_p1_wait <= '0;
                        if (p1_len != '0) begin
                            r_state     <= S_BURST;
                            r_cur_addr  <= p1_addr;
                            r_remaining <= p1_len;
                        end
                    end else if (p0_req & p1_req & ~w_tail) begin
                        r_p1_wait <= r_p1_wait + 1'b1;
                    end else begin
                        r_p1_wait <= '0;
                    end
                end
                S_BURST: begin
                    if (w_p0_preempt) begin
                        r_p0_wait <= '0;
                    end else begin
                        r_p0_wait   <= p0_req ? (r_p0_wait + 1'b1) : '0;
                        r_cur_addr  <= r_cur_addr + 32'd4;
                        r_remaining <= r_remaining - 1'b1;
                        if (w_last_read) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

    localparam int P0S = 4;
    localparam int P1S = 16;
    localparam int EVN = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we;
    logic [31:0] p0_addr, p0_wdata;
    logic [4:0]  p0_aluCode;
    logic        p0_gnt, stall;
    logic [31:0] p0_rdata;
    logic        p1_req;
    logic [31:0] p1_addr;
    logic [7:0]  p1_len;
    logic        p1_busy, p1_valid, p1_done;
    logic [31:0] p1_rdata;
    logic [31:0] mem_Address, mem_WriteData, mem_ReadData;
    logic        mem_MemWrite, mem_MemRead;
    logic [4:0]  mem_aluCode;

    logic [31:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // behavioural reference model state
    bit          m_burst;
    int          m_left, m_p0w, m_p1w, m_busy_end;
    logic [31:0] m_addr;
    bit          ev_valid [0:EVN-1];
    logic [31:0] ev_data  [0:EVN-1];
    bit          ev_done  [0:EVN-1];

    // expectations for the current cycle
    logic        exp_p0_gnt, exp_stall, exp_busy, exp_valid, exp_done;
    logic        exp_mrd, exp_mwr;
    logic [31:0] exp_addr, exp_rdata, exp_p0_rdata;
    logic [4:0]  exp_code;

    always #5 clk = ~clk;

    assign mem_ReadData = mem[mem_Address[11:2]];
    always @(posedge clk) if (mem_MemWrite) mem[mem_Address[11:2]] <= mem_WriteData;

    dmem_port_arbiter #(.LEN_W(8), .P0_STARVE(P0S), .P1_STARVE(P1S)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_aluCode(p0_aluCode), .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .stall(stall),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_len(p1_len), .p1_busy(p1_busy),
        .p1_valid(p1_valid), .p1_rdata(p1_rdata), .p1_done(p1_done),
        .mem_Address(mem_Address), .mem_WriteData(mem_WriteData), .mem_MemWrite(mem_MemWrite),
        .mem_MemRead(mem_MemRead), .mem_aluCode(mem_aluCode), .mem_ReadData(mem_ReadData)
    );

    task automatic model_reset();
        m_burst = 0; m_left = 0; m_p0w = 0; m_p1w = 0; m_busy_end = -10; m_addr = '0;
        for (int i = 0; i < EVN; i++) begin
            ev_valid[i] = 0; ev_data[i] = '0; ev_done[i] = 0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives one cycle of inputs, then derives expectations and advances the model
    task automatic drive_cycle(input logic p0r, input logic p0w, input logic [31:0] p0a,
                               input logic [31:0] p0d, input logic [4:0] code,
                               input logic p1r, input logic [31:0] p1a, input logic [7:0] p1l);
        bit tail, accept, rd, was_burst;
        p0_req = p0r; p0_we = p0w; p0_addr = p0a; p0_wdata = p0d; p0_aluCode = code;
        p1_req = p1r; p1_addr = p1a; p1_len = p1l;
        #2;
        tail = (cyc <= m_busy_end);
        was_burst = m_burst;
        exp_valid = ev_valid[cyc]; exp_rdata = ev_data[cyc]; exp_done = ev_done[cyc];
        exp_p0_rdata = mem[p0a[11:2]];
        accept = 0; rd = 0; exp_addr = '0;
        if (!m_burst) begin
            accept = p1r && !tail && (!p0r || m_p1w == P1S);
            exp_p0_gnt = p0r && !accept;
            if (accept) begin
                m_p1w = 0;
                if (p1l == 0) begin
                    ev_done[cyc+1] = 1; m_busy_end = cyc + 1;
                end else begin
                    m_burst = 1; m_addr = p1a; m_left = int'(p1l);
                end
            end else begin
                m_p1w = (p0r && p1r && !tail) ? m_p1w + 1 : 0;
            end
            m_p0w = 0;
        end else begin
            exp_p0_gnt = p0r && (m_p0w == P0S);
            if (exp_p0_gnt) begin
                m_p0w = 0;
            end else begin
                rd = 1; exp_addr = m_addr;
                ev_valid[cyc+1] = 1; ev_data[cyc+1] = mem[m_addr[11:2]];
                m_addr = m_addr + 32'd4; m_left--;
                m_p0w = p0r ? m_p0w + 1 : 0;
                if (m_left == 0) begin
                    m_burst = 0; ev_done[cyc+2] = 1; m_busy_end = cyc + 2;
                end
            end
        end
        exp_busy  = was_burst || tail || accept;
        exp_stall = p0r && !exp_p0_gnt;
        exp_mrd   = exp_p0_gnt ? !p0w : rd;
        exp_mwr   = exp_p0_gnt && p0w;
        exp_code  = exp_p0_gnt ? code : 5'd0;
        if (exp_p0_gnt) exp_addr = p0a;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle(0, 0, '0, '0, '0, 0, '0, '0);
            next_cycle();
        end
    endtask

    task automatic test_reset();
        n_checks++; if (p1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_p1_valid: got %b want 0", p1_valid); end
        n_checks++; if (p1_done !== 1'b0) begin n_fail++; $display("FAIL reset_p1_done: got %b want 0", p1_done); end
        n_checks++; if (p1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_p1_busy: got %b want 0", p1_busy); end
        n_checks++; if (p1_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_p1_rdata: got %h want 0", p1_rdata); end
        n_checks++; if ({mem_MemRead, mem_MemWrite} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_ctl: got %b want 00", {mem_MemRead, mem_MemWrite}); end
    endtask

    task automatic test_p0_idle();
        logic [31:0] d;
        drive_cycle(1, 0, 32'h10, '0, 5'd3, 0, '0, '0);
        n_checks++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL idle_p0_gnt: got %b want 1", p0_gnt); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %b want 0", stall); end
        n_checks++; if (p0_rdata !== mem[4]) begin n_fail++; $display("FAIL idle_p0_rdata: got %h want %h", p0_rdata, mem[4]); end
        n_checks++; if (mem_MemRead !== 1'b1 || mem_Address !== 32'h10) begin n_fail++; $display("FAIL idle_mem_read: got %b/%h want 1/00000010", mem_MemRead, mem_Address); end
        next_cycle();
        d = 32'hCAFE_0123;
        drive_cycle(1, 1, 32'h20, d, 5'd0, 0, '0, '0);
        n_checks++; if (mem_MemWrite !== 1'b1 || mem_WriteData !== d) begin n_fail++; $display("FAIL idle_store: got %b/%h want 1/%h", mem_MemWrite, mem_WriteData, d); end
        next_cycle();
        drive_cycle(1, 0, 32'h20, '0, 5'd3, 0, '0, '0);
        n_checks++; if (p0_rdata !== d) begin n_fail++; $display("FAIL idle_load_back: got %h want %h", p0_rdata, d); end
        next_cycle();
    endtask

    task automatic test_burst();
        int nv, nd;
        nv = 0; nd = 0;
        drive_cycle(0, 0, '0, '0, '0, 1, 32'h100, 8'd4);
        n_checks++; if (p1_busy !== 1'b1) begin n_fail++; $display("FAIL burst_accept_busy: got %b want 1", p1_busy); end
        n_checks++; if (mem_MemRead !== 1'b0) begin n_fail++; $display("FAIL burst_accept_noread: got %b want 0", mem_MemRead); end
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(0, 0, '0, '0, '0, (i < 3), 32'h500, 8'd2);
            n_checks++; if (p1_valid !== exp_valid) begin n_fail++; $display("FAIL burst_valid[%0d]: got %b want %b", i, p1_valid, exp_valid); end
            n_checks++; if (p1_done !== exp_done) begin n_fail++; $display("FAIL burst_done[%0d]: got %b want %b", i, p1_done, exp_done); end
            if (exp_valid) begin
                n_checks++; if (p1_rdata !== mem[10'h40 + nv]) begin n_fail++; $display("FAIL burst_rdata[%0d]: got %h want %h", nv, p1_rdata, mem[10'h40 + nv]); end
            end
            if (p1_valid === 1'b1) nv++;
            if (p1_done === 1'b1) nd++;
            next_cycle();
        end
        n_checks++; if (nv != 4) begin n_fail++; $display("FAIL burst_word_count: got %0d want 4", nv); end
        n_checks++; if (nd != 1) begin n_fail++; $display("FAIL burst_done_count: got %0d want 1", nd); end
    endtask

    task automatic test_preempt();
        int nv, ns, gat;
        nv = 0; ns = 0; gat = -1;
        drive_cycle(0, 0, '0, '0, '0, 1, 32'h200, 8'd8);
        next_cycle();
        for (int i = 0; i < 14; i++) begin
            drive_cycle((i < 5), 0, 32'h44, '0, 5'd3, 0, '0, '0);
            n_checks++; if (p0_gnt !== exp_p0_gnt) begin n_fail++; $display("FAIL pre_gnt[%0d]: got %b want %b", i, p0_gnt, exp_p0_gnt); end
            n_checks++; if (p1_valid !== exp_valid) begin n_fail++; $display("FAIL pre_valid[%0d]: got %b want %b", i, p1_valid, exp_valid); end
            n_checks++; if (p1_done !== exp_done) begin n_fail++; $display("FAIL pre_done[%0d]: got %b want %b", i, p1_done, exp_done); end
            if (exp_valid) begin
                n_checks++; if (p1_rdata !== mem[10'h80 + nv]) begin n_fail++; $display("FAIL pre_rdata[%0d]: got %h want %h", nv, p1_rdata, mem[10'h80 + nv]); end
            end
            if (p1_valid === 1'b1) nv++;
            if (stall === 1'b1) ns++;
            if (p0_gnt === 1'b1 && gat < 0) gat = i;
            next_cycle();
        end
        n_checks++; if (ns != P0S) begin n_fail++; $display("FAIL pre_stall_count: got %0d want %0d", ns, P0S); end
        n_checks++; if (gat != P0S) begin n_fail++; $display("FAIL pre_grant_cycle: got %0d want %0d", gat, P0S); end
        n_checks++; if (nv != 8) begin n_fail++; $display("FAIL pre_word_count: got %0d want 8", nv); end
    endtask

    task automatic test_p1_starve();
        int ng;
        bit seen;
        ng = 0; seen = 0;
        idle_cycles(2);
        for (int i = 0; i < 24 && !seen; i++) begin
            drive_cycle(1, 0, 32'h8, '0, 5'd3, 1, 32'h400, 8'd2);
            n_checks++; if (p0_gnt !== exp_p0_gnt) begin n_fail++; $display("FAIL starve_gnt[%0d]: got %b want %b", i, p0_gnt, exp_p0_gnt); end
            if (p1_busy === 1'b1) begin
                seen = 1;
                n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL starve_win_stall: got %b want 1", stall); end
            end else if (p0_gnt === 1'b1) begin
                ng++;
            end
            next_cycle();
        end
        n_checks++; if (!seen || ng != P1S) begin n_fail++; $display("FAIL starve_p0_wins: got %0d (p1 won=%0d) want %0d", ng, seen, P1S); end
        idle_cycles(6);
    endtask

    task automatic test_len_zero();
        drive_cycle(0, 0, '0, '0, '0, 1, 32'h600, 8'd0);
        n_checks++; if (mem_MemRead !== 1'b0) begin n_fail++; $display("FAIL len0_read: got %b want 0", mem_MemRead); end
        next_cycle();
        drive_cycle(0, 0, '0, '0, '0, 0, '0, '0);
        n_checks++; if (p1_done !== 1'b1 || p1_valid !== 1'b0 || mem_MemRead !== 1'b0) begin n_fail++; $display("FAIL len0_done: got done=%b valid=%b rd=%b want 1/0/0", p1_done, p1_valid, mem_MemRead); end
        next_cycle();
        drive_cycle(0, 0, '0, '0, '0, 0, '0, '0);
        n_checks++; if (p1_done !== 1'b0 || p1_busy !== 1'b0) begin n_fail++; $display("FAIL len0_after: got done=%b busy=%b want 0/0", p1_done, p1_busy); end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        drive_cycle(0, 0, '0, '0, '0, 1, 32'h300, 8'd8);
        next_cycle();
        idle_cycles(2);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({p1_valid, p1_busy, p1_done, mem_MemRead, mem_MemWrite} !== 5'b0) begin n_fail++; $display("FAIL rstmid_outputs: got %b want 00000", {p1_valid, p1_busy, p1_done, mem_MemRead, mem_MemWrite}); end
        model_reset();
        next_cycle();
        rst_n = 1'b1;
        drive_cycle(1, 0, 32'h10, '0, 5'd3, 0, '0, '0);
        n_checks++; if (p0_gnt !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_p0: got gnt=%b stall=%b want 1/0", p0_gnt, stall); end
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(0, 0, '0, '0, '0, 0, '0, '0);
            n_checks++; if (p1_done !== 1'b0 || p1_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet[%0d]: got done=%b valid=%b want 0/0", i, p1_done, p1_valid); end
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic [31:0] pa, a1;
        for (int i = 0; i < 600; i++) begin
            pa = 32'($urandom_range(0, 1023)) << 2;
            a1 = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 : (32'($urandom_range(0, 1023)) << 2);
            drive_cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), pa, $urandom,
                        5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0), a1,
                        8'($urandom_range(0, 6)));
            n_checks++; if (p0_gnt !== exp_p0_gnt) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b want %b", cyc, p0_gnt, exp_p0_gnt); end
            n_checks++; if (stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall@%0d: got %b want %b", cyc, stall, exp_stall); end
            n_checks++; if (p1_busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, p1_busy, exp_busy); end
            n_checks++; if (p1_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, p1_valid, exp_valid); end
            n_checks++; if (p1_done !== exp_done) begin n_fail++; $display("FAIL rnd_done@%0d: got %b want %b", cyc, p1_done, exp_done); end
            n_checks++; if ({mem_MemRead, mem_MemWrite} !== {exp_mrd, exp_mwr}) begin n_fail++; $display("FAIL rnd_memctl@%0d: got %b want %b", cyc, {mem_MemRead, mem_MemWrite}, {exp_mrd, exp_mwr}); end
            if (exp_mrd || exp_mwr) begin
                n_checks++; if (mem_Address !== exp_addr || mem_aluCode !== exp_code) begin n_fail++; $display("FAIL rnd_memaddr@%0d: got %h/%h want %h/%h", cyc, mem_Address, mem_aluCode, exp_addr, exp_code); end
            end
            if (exp_valid) begin
                n_checks++; if (p1_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_p1_rdata@%0d: got %h want %h", cyc, p1_rdata, exp_rdata); end
            end
            if (exp_p0_gnt && !p0_we) begin
                n_checks++; if (p0_rdata !== exp_p0_rdata) begin n_fail++; $display("FAIL rnd_p0_rdata@%0d: got %h want %h", cyc, p0_rdata, exp_p0_rdata); end
            end
            next_cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_aluCode = '0;
        p1_req = 0; p1_addr = '0; p1_len = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_p0_idle();
        test_burst();
        test_preempt();
        test_p1_starve();
        test_len_zero();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
